// File: rtl/esc_receiver_array.sv
// rtl/esc_receiver_array.sv - multi-lane escalation receiver with ping/escalation decode and integrity-fault counting
module esc_receiver_array #(
    parameter int NumCh = 4,
    parameter int CntW  = 8,
    parameter bit Latch = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumCh-1:0]      esc_p_i,
    input  logic [NumCh-1:0]      esc_n_i,
    input  logic                  cnt_clr_i,
    output logic [NumCh-1:0]      resp_p_o,
    output logic [NumCh-1:0]      resp_n_o,
    output logic [NumCh-1:0]      esc_en_o,
    output logic [NumCh-1:0]      int_fail_o,
    output logic [NumCh*CntW-1:0] int_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        PING0,
        PING1,
        ESC_RESP,
        SIG_INT
    } state_t;

    for (genvar k = 0; k < NumCh; k++) begin : g_lane
        state_t          state_q, state_d;
        logic            rp_q, rp_d;
        logic            rn_q, rn_d;
        logic            en_q, en_d;
        logic [CntW-1:0] cnt_q, cnt_d;
        logic            sigint;
        logic            esc;

        assign sigint = (esc_p_i[k] == esc_n_i[k]);
        assign esc    = esc_p_i[k] & ~esc_n_i[k];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                rp_q    <= 1'b0;
                rn_q    <= 1'b1;
                en_q    <= 1'b0;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                rp_q    <= rp_d;
                rn_q    <= rn_d;
                en_q    <= en_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:     if (esc) state_d = CHECK;
                CHECK:    state_d = esc ? ESC_RESP : PING0;
                PING0:    state_d = PING1;
                PING1:    state_d = IDLE;
                ESC_RESP: if (!esc) state_d = IDLE;
                SIG_INT:  state_d = IDLE;
                default:  state_d = IDLE;
            endcase
            if (sigint) state_d = SIG_INT;
        end

        // Response rails are computed from the next state so the registers hold Moore outputs.
        always_comb begin
            rp_d = 1'b0;
            rn_d = 1'b1;
            case (state_d)
                CHECK, PING1: begin
                    rp_d = 1'b1;
                    rn_d = 1'b0;
                end
                ESC_RESP: begin
                    rp_d = (state_q == ESC_RESP) ? ~rp_q : 1'b0;
                    rn_d = ~rp_d;
                end
                SIG_INT: begin
                    rp_d = (state_q == SIG_INT) ? ~rp_q : 1'b1;
                    rn_d = rp_d;
                end
                default: begin
                    rp_d = 1'b0;
                    rn_d = 1'b1;
                end
            endcase
        end

        always_comb begin
            en_d  = (state_d == ESC_RESP) || (Latch && en_q);
            cnt_d = cnt_q;
            if (cnt_clr_i) begin
                cnt_d = '0;
            end else if (state_d == SIG_INT && state_q != SIG_INT && cnt_q != {CntW{1'b1}}) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end

        assign resp_p_o[k]                = rp_q;
        assign resp_n_o[k]                = rn_q;
        assign esc_en_o[k]                = en_q;
        assign int_fail_o[k]              = (state_q == SIG_INT);
        assign int_cnt_o[k*CntW +: CntW]  = cnt_q;
    end

endmodule

// File: doc/esc_receiver_array.md
# esc_receiver_array

Parametrised multi-channel escalation receiver for the alert-handler path. Each of NumCh lanes decodes a differential escalation pair (esc_p/esc_n), distinguishes ping from real escalation, answers on a differential response pair (resp_p/resp_n), and detects signal-integrity faults. It extends the single-lane escalation interface with:
- a per-lane saturating integrity-fault counter;
- an optional sticky escalation mode.

It sits between the escalation sender fabric and local consumers of the escalation enable.

## Interface
- NumCh, default 4: number of independent escalation lanes (1..32).
- CntW, default 8: width of each lane's integrity-fault counter.
- Latch, default 0: 1 makes esc_en_o sticky per lane until reset; 0 tracks the protocol.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- esc_p_i  in  NumCh  escalation positive rail, one bit per lane.
- esc_n_i  in  NumCh  escalation negative rail, one bit per lane.
- cnt_clr_i  in  1  synchronous clear of all fault counters.
- resp_p_o  out  NumCh  response positive rail.
- resp_n_o  out  NumCh  response negative rail.
- esc_en_o  out  NumCh  escalation enable to local consumers.
- int_fail_o  out  NumCh  lane currently in integrity-fault state.
- int_cnt_o  out  NumCh*CntW  per-lane fault counters; lane k occupies bits [k*CntW +: CntW].

## Operation
Lanes are fully independent and share only the clock, reset and cnt_clr_i.

Per-lane decode:
- sigint = (esc_p == esc_n).
- esc = esc_p & ~esc_n.

Per-lane FSM states are Idle, Check, Ping0, Ping1, EscResp and SigInt. Transitions are evaluated on each edge; sigint has highest priority in every state.
- Any state, sigint=1: go to SigInt.
- Idle: esc=1 goes to Check; otherwise stay.
- Check: esc=1 goes to EscResp; esc=0 goes to Ping0.
- Ping0: go to Ping1 unconditionally (when no sigint).
- Ping1: go to Idle unconditionally (when no sigint).
- EscResp: stay while esc=1; esc=0 goes to Idle.
- SigInt: stay while sigint=1; otherwise go to Idle.

Outputs are registered and reflect the current state (Moore outputs):
- resp_p by state: Idle 0, Check 1, Ping0 0, Ping1 1.
- resp_n is the complement of resp_p in all states except SigInt.
- EscResp: resp_p starts at 0 on entry and toggles every cycle in state. resp_n = ~resp_p.
- SigInt: resp_p = resp_n. Both start at 1 on entry and toggle together every cycle.
- esc_en_o = (state == EscResp). With Latch=1 it is set on entry to EscResp and held until rst_i, including through SigInt and Idle.
- int_fail_o = (state == SigInt).

Fault counter:
- Increments by 1 on each entry into SigInt (a transition from any other state).
- Saturates at 2^CntW-1; no wrap.
- cnt_clr_i=1 zeroes all counters on the next edge. Clear wins over a simultaneous increment.

Reset values (asynchronous on rst_i=1):
- State Idle; resp_p_o=0, resp_n_o=1 for all lanes.
- esc_en_o=0, int_fail_o=0, int_cnt_o=0, Latch flags cleared.
- Reset mid-escalation or mid-ping aborts immediately; the lane returns to Idle values without waiting for an edge.

## Timing
- Edge 0 is the first rising edge sampling esc=1.
- Ping (esc high for exactly 1 cycle): after edges 0,1,2,3, resp_p = 1,0,1,0. The lane is Idle after edge 3.
- Escalation (esc held high): Check after edge 0, EscResp after edge 1. esc_en_o=1 from edge 1, i.e. 2 cycles after the first esc-high cycle begins. resp_p toggles 0,1,0,... from edge 1.
- A ping that arrives during Ping0 or Ping1 is ignored until Idle.
- An esc deassert while in EscResp: esc_en_o drops at the next edge (Latch=0).
- sigint: int_fail_o=1 and the counter increments on the edge that samples it. Exit to Idle occurs at the first edge sampling sigint=0.
- No combinational path from any input to any output.

## Test plan
- Ping, single lane, NumCh=4: 1-cycle esc pulse on lane 2 -> resp_p[2] sequence 1,0,1,0 over 4 edges; esc_en_o=0 throughout; other lanes stay resp_p=0, resp_n=1.
- Escalation: hold lane 0 esc for 6 cycles -> esc_en_o[0] high after edge 1 until 1 edge after release; resp_p[0] toggles 0,1,0,1,0; resp_n[0] is complementary throughout.
- Integrity: drive esc_p=esc_n=1 on lane 1 for 3 cycles -> int_fail_o[1]=1 for 3 cycles; resp_p=resp_n, both toggling 1,0,1; count[1]=1; esc_en_o[1]=0.
- Saturation/clear, CntW=2: inject 5 separate sigint episodes -> count=3 (saturated); assert cnt_clr_i on the same edge as a 6th SigInt entry -> count=0.
- Latch=1: escalate lane 3 for 3 cycles, release, then inject sigint -> esc_en_o[3] stays 1 throughout; only rst_i=1 clears it, asynchronously.
- Reset mid-operation: assert rst_i during EscResp on all lanes -> resp_p=0, resp_n=1, esc_en_o=0 immediately, before the next clock edge.
